// File: rtl/debounce_multi_pkg.sv
// Shared constants and types for the multi-channel button conditioner.
// Defaults target a 12 MHz clock with a 10 ms debounce window and a 1 s long press.
package debounce_multi_pkg;

  localparam int CLK_FREQ_HZ        = 12_000_000;
  localparam int DEBOUNCE_RATE_HZ   = 100;
  localparam int DEF_CLK_ITER_MAX   = CLK_FREQ_HZ / DEBOUNCE_RATE_HZ - 1;
  localparam int DEF_CLK_ITER_WIDTH = 17;
  localparam int DEF_LONG_TICKS     = 100;

  // Registered per-channel outputs, grouped so the top can fan them out by field.
  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic long_press;
  } btn_evt_t;

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-flop synchroniser, stability counter, debounced level,
// press/release pulses and a long-press counter advanced by the shared tick.
module debounce_ch
  import debounce_multi_pkg::*;
#(
  parameter int CLK_ITER_WIDTH = DEF_CLK_ITER_WIDTH,
  parameter int CLK_ITER_MAX   = DEF_CLK_ITER_MAX,
  parameter int LONG_TICKS     = DEF_LONG_TICKS,
  parameter int ACTIVE_LOW     = 0
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     btn_i,
  input  logic     tick_i,
  output btn_evt_t evt_o
);

  localparam int HOLD_W = $clog2(LONG_TICKS + 1);
  localparam logic [CLK_ITER_WIDTH-1:0] ITER_MAX  = CLK_ITER_WIDTH'(CLK_ITER_MAX);
  localparam logic [HOLD_W-1:0]         LONG_MAX  = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0]         LONG_LAST = HOLD_W'(LONG_TICKS - 1);

  logic                      pol;
  logic                      s;
  logic [1:0]                sync_q, sync_d;
  logic [CLK_ITER_WIDTH-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0]         hold_q, hold_d;
  logic                      level_q, level_d;
  logic                      rise_q, rise_d;
  logic                      fall_q, fall_d;
  logic                      long_q, long_d;
  logic                      accept;

  assign pol = btn_i ^ (ACTIVE_LOW != 0);
  assign s   = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], pol};
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    hold_d  = hold_q;
    long_d  = 1'b0;
    accept  = 1'b0;

    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == ITER_MAX) begin
      accept  = 1'b1;
      level_d = s;
      cnt_d   = '0;
      rise_d  = s;
      fall_d  = ~s;
    end else begin
      cnt_d = cnt_q + CLK_ITER_WIDTH'(1);
    end

    // An accept while pressed is a release; it beats a long press landing on the same edge.
    if (!level_q || accept) begin
      hold_d = '0;
    end else if (tick_i && (hold_q < LONG_MAX)) begin
      hold_d = hold_q + HOLD_W'(1);
      long_d = (hold_q == LONG_LAST);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      long_q  <= long_d;
    end
  end

  assign evt_o = '{level: level_q, rise: rise_q, fall: fall_q, long_press: long_q};

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel button conditioner: a shared free-running period prescaler
// feeding NUM_CH independent debounce_ch instances.
module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CLK_ITER_WIDTH = DEF_CLK_ITER_WIDTH,
  parameter int CLK_ITER_MAX   = DEF_CLK_ITER_MAX,
  parameter int LONG_TICKS     = DEF_LONG_TICKS,
  parameter int ACTIVE_LOW     = 0
) (
  input  logic              clk,
  input  logic              rstInput,
  input  logic [NUM_CH-1:0] btnInput,
  output logic [NUM_CH-1:0] btnLevel,
  output logic [NUM_CH-1:0] btnRise,
  output logic [NUM_CH-1:0] btnFall,
  output logic [NUM_CH-1:0] btnLong
);

  localparam logic [CLK_ITER_WIDTH-1:0] ITER_MAX = CLK_ITER_WIDTH'(CLK_ITER_MAX);

  logic [CLK_ITER_WIDTH-1:0] pre_q, pre_d;
  logic                      tick;
  btn_evt_t                  evt [NUM_CH];

  // Tick marks the cycle in which the prescaler wraps back to zero.
  assign tick  = (pre_q == ITER_MAX);
  assign pre_d = tick ? '0 : pre_q + CLK_ITER_WIDTH'(1);

  always_ff @(posedge clk or posedge rstInput) begin
    if (rstInput) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_ch #(
      .CLK_ITER_WIDTH(CLK_ITER_WIDTH),
      .CLK_ITER_MAX  (CLK_ITER_MAX),
      .LONG_TICKS    (LONG_TICKS),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_ch (
      .clk_i (clk),
      .rst_i (rstInput),
      .btn_i (btnInput[g]),
      .tick_i(tick),
      .evt_o (evt[g])
    );

    assign btnLevel[g] = evt[g].level;
    assign btnRise[g]  = evt[g].rise;
    assign btnFall[g]  = evt[g].fall;
    assign btnLong[g]  = evt[g].long_press;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios plus random pin activity on an
// active-high and an active-low instance, checked against a window-based model.
`timescale 1ns/1ps
module tb_debounce_multi;

  localparam int NUM_CH = 4;
  localparam int ITW    = 2;
  localparam int MAX    = 2;
  localparam int LONG   = 3;
  localparam int P      = MAX + 1;
  localparam int HW     = MAX + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #41.667 clk = ~clk;

  logic [NUM_CH-1:0] btn_h = '0;
  logic [NUM_CH-1:0] btn_l = '1;
  logic [NUM_CH-1:0] lvl_h, rise_h, fall_h, long_h;
  logic [NUM_CH-1:0] lvl_l, rise_l, fall_l, long_l;

  debounce_multi #(
    .NUM_CH(NUM_CH), .CLK_ITER_WIDTH(ITW), .CLK_ITER_MAX(MAX), .LONG_TICKS(LONG), .ACTIVE_LOW(0)
  ) dut_h (
    .clk(clk), .rstInput(rst), .btnInput(btn_h),
    .btnLevel(lvl_h), .btnRise(rise_h), .btnFall(fall_h), .btnLong(long_h)
  );

  debounce_multi #(
    .NUM_CH(NUM_CH), .CLK_ITER_WIDTH(ITW), .CLK_ITER_MAX(MAX), .LONG_TICKS(LONG), .ACTIVE_LOW(1)
  ) dut_l (
    .clk(clk), .rstInput(rst), .btnInput(btn_l),
    .btnLevel(lvl_l), .btnRise(rise_l), .btnFall(fall_l), .btnLong(long_l)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A level flips once the last MAX+1 synchronised samples (pins from two edges
  // earlier) all disagree with it. A long press lands on the LONG-th prescaler
  // wrap after the press edge, the prescaler being a free-running edge count mod P.
  logic [NUM_CH-1:0] hist [2][HW];
  logic [NUM_CH-1:0] m_lvl [2];
  int                long_due [2][NUM_CH];
  int                edge_k;
  logic [15:0]       exp_q_h[$];
  logic [15:0]       exp_q_l[$];
  logic [15:0]       e_h, e_l;

  task automatic model_reset();
    edge_k = 0;
    for (int d = 0; d < 2; d++) begin
      m_lvl[d] = '0;
      for (int j = 0; j < HW; j++) hist[d][j] = '0;
      for (int c = 0; c < NUM_CH; c++) long_due[d][c] = -1;
    end
  endtask

  task automatic model_edge(input int d, input logic [NUM_CH-1:0] pin, output logic [15:0] e);
    logic [NUM_CH-1:0] pv, lvl_n, rs, fl, lg;
    logic acc;
    int t;
    pv = (d == 1) ? ~pin : pin;
    for (int j = HW - 1; j > 0; j--) hist[d][j] = hist[d][j-1];
    hist[d][0] = pv;
    lvl_n = m_lvl[d];
    rs = '0; fl = '0; lg = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      acc = 1'b1;
      for (int i = 0; i <= MAX; i++)
        if (hist[d][2+i][c] == m_lvl[d][c]) acc = 1'b0;
      if (m_lvl[d][c] && !acc && edge_k == long_due[d][c]) lg[c] = 1'b1;
      if (acc) begin
        lvl_n[c] = ~m_lvl[d][c];
        rs[c]    = lvl_n[c];
        fl[c]    = ~lvl_n[c];
        if (lvl_n[c]) begin
          t = edge_k + 1;
          while (t % P != MAX) t++;
          long_due[d][c] = t + (LONG - 1) * P;
        end else begin
          long_due[d][c] = -1;
        end
      end
    end
    m_lvl[d] = lvl_n;
    e = {lvl_n, rs, fl, lg};
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
      exp_q_h.delete();
      exp_q_l.delete();
    end else begin
      model_edge(0, btn_h, e_h);
      exp_q_h.push_back(e_h);
      model_edge(1, btn_l, e_l);
      exp_q_l.push_back(e_l);
      edge_k++;
    end
  end

  // ---------------- monitor ----------------
  logic [15:0] mon_exp;
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q_h.size() > 0) begin
        mon_exp = exp_q_h.pop_front();
        check("mon_h {lvl,rise,fall,long}", {lvl_h, rise_h, fall_h, long_h}, mon_exp);
      end
      if (exp_q_l.size() > 0) begin
        mon_exp = exp_q_l.pop_front();
        check("mon_l {lvl,rise,fall,long}", {lvl_l, rise_l, fall_l, long_l}, mon_exp);
      end
    end
  end

  // ---------------- driver helpers ----------------
  function automatic logic [NUM_CH-1:0] sel_h(input int kind);
    case (kind)
      0:       return rise_h;
      1:       return fall_h;
      default: return long_h;
    endcase
  endfunction

  // Cycles (negedges) until the chosen event shows on channel ch; -1 on timeout.
  task automatic wait_evt(input int kind, input int ch, input int budget, output int cyc);
    logic [NUM_CH-1:0] v;
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      v = sel_h(kind);
      if (v[ch]) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic count_evt(input int kind, input int ch, input int cycles, output int n);
    logic [NUM_CH-1:0] v;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      v = sel_h(kind);
      if (v[ch]) n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int c, n, n3;
    logic moved, seen, three;

    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    check("reset_state_h", {lvl_h, rise_h, fall_h, long_h}, 16'h0);
    check("reset_state_l", {lvl_l, rise_l, fall_l, long_l}, 16'h0);

    // Clean press and release on ch0
    btn_h[0] = 1'b1;
    wait_evt(0, 0, 20, c);
    check("press_latency_ch0", c, 5);
    check("press_level_ch0", lvl_h[0], 1'b1);
    @(negedge clk);
    check("rise_width_ch0", rise_h[0], 1'b0);

    // Asynchronous reset mid-press
    @(negedge clk);
    #10 rst = 1'b1;
    #1;
    check("async_reset_h", {lvl_h, rise_h, fall_h, long_h}, 16'h0);
    check("async_reset_l", {lvl_l, rise_l, fall_l, long_l}, 16'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    wait_evt(0, 0, 20, c);
    check("rerise_after_reset_ch0", c, 5);

    @(negedge clk);
    btn_h[0] = 1'b0;
    wait_evt(1, 0, 20, c);
    check("release_latency_ch0", c, 5);

    // Bounce on ch1: 32 toggles, an odd number per cycle so samples alternate
    moved = 1'b0;
    n3 = 8;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (lvl_h[1]) moved = 1'b1;
      three = (n3 > 0) && ((n3 == 16 - cyc) || ($urandom_range(0, 1) == 1));
      if (three) n3--;
      repeat (three ? 3 : 1) begin
        #1 btn_h[1] = ~btn_h[1];
      end
    end
    @(negedge clk);
    if (lvl_h[1]) moved = 1'b1;
    check("bounce_level_stable_ch1", moved, 1'b0);
    btn_h[1] = 1'b1;
    count_evt(0, 1, 20, n);
    check("bounce_single_rise_ch1", n, 1);
    btn_h[1] = 1'b0;
    wait_evt(1, 1, 20, c);
    check("bounce_release_ch1", c, 5);

    // Glitch on ch2 shorter than the stability window
    @(negedge clk);
    btn_h[2] = 1'b1;
    repeat (2) @(negedge clk);
    btn_h[2] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (lvl_h[2]) seen = 1'b1;
    end
    check("glitch_no_level_ch2", seen, 1'b0);

    // Long press on ch3, random prescaler phase
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    btn_h[3] = 1'b1;
    wait_evt(0, 3, 20, c);
    check("long_rise_latency_ch3", c, 5);
    wait_evt(2, 3, 15, c);
    check("long_latency_in_7_to_9_ch3", (c >= 7 && c <= 9), 1'b1);
    count_evt(2, 3, 10, n);
    check("long_single_pulse_ch3", n, 0);
    btn_h[3] = 1'b0;
    wait_evt(1, 3, 20, c);
    check("long_release_ch3", c, 5);

    // Short press on ch3: released well before the long threshold
    @(negedge clk);
    btn_h[3] = 1'b1;
    wait_evt(0, 3, 20, c);
    check("short_rise_ch3", c, 5);
    btn_h[3] = 1'b0;
    count_evt(2, 3, 15, n);
    check("short_no_long_ch3", n, 0);

    // Simultaneous press on the active-low instance
    @(negedge clk);
    check("al_idle_level", lvl_l, 4'h0);
    btn_l = 4'h0;
    c = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rise_l != 4'h0) begin
        c = i;
        break;
      end
    end
    check("al_simultaneous_rise", rise_l, 4'hF);
    check("al_rise_latency", c, 5);
    btn_l = 4'hF;
    repeat (10) @(negedge clk);
    check("al_released_level", lvl_l, 4'h0);

    // Random activity on both instances, with one async reset partway through
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 200) begin
        #10 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) btn_h = btn_h ^ 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) btn_l = btn_l ^ 4'($urandom_range(0, 15));
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
